// File: rtl/rv_decode_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation codes,
// immediate kinds, FSM states and the ID/EX entry layout.
package rv_decode_pkg;

    localparam int XLEN_P    = 32;
    localparam int REG_AW_P  = 5;
    localparam int ALUOP_W_P = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [4:0] ALU_ADD     = 5'd0;
    localparam logic [4:0] ALU_SUB     = 5'd1;
    localparam logic [4:0] ALU_XOR     = 5'd2;
    localparam logic [4:0] ALU_OR      = 5'd3;
    localparam logic [4:0] ALU_AND     = 5'd4;
    localparam logic [4:0] ALU_SLL     = 5'd5;
    localparam logic [4:0] ALU_SRL     = 5'd6;
    localparam logic [4:0] ALU_SRA     = 5'd7;
    localparam logic [4:0] ALU_SLT     = 5'd8;
    localparam logic [4:0] ALU_SLTU    = 5'd9;
    localparam logic [4:0] ALU_ADDI    = 5'd10;
    localparam logic [4:0] ALU_XORI    = 5'd11;
    localparam logic [4:0] ALU_ORI     = 5'd12;
    localparam logic [4:0] ALU_ANDI    = 5'd13;
    localparam logic [4:0] ALU_SLLI    = 5'd14;
    localparam logic [4:0] ALU_SRLI    = 5'd15;
    localparam logic [4:0] ALU_SRAI    = 5'd16;
    localparam logic [4:0] ALU_SLTI    = 5'd17;
    localparam logic [4:0] ALU_SLTIU   = 5'd18;
    localparam logic [4:0] ALU_STORE   = 5'd20;
    localparam logic [4:0] ALU_ILLEGAL = 5'd31;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_U,
        IMM_SHAMT
    } imm_type_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_PUSH
    } dec_state_t;

    typedef struct packed {
        logic [XLEN_P-1:0]    operand1;
        logic [XLEN_P-1:0]    operand2;
        logic [XLEN_P-1:0]    store_data;
        logic [ALUOP_W_P-1:0] alu_op;
        logic                 mem_read;
        logic                 mem_write;
        logic                 reg_write;
        logic [REG_AW_P-1:0]  rd;
        logic                 illegal;
    } id_ex_t;

endpackage

// File: rtl/idex_queue.sv
// Circular FIFO with flush and occupancy; head is read straight
// from the storage flops so it only changes on push/pop/flush.
module idex_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic                   head_valid,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && (count != FULL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_valid = (count != '0);
    assign head_data  = mem[rd_ptr];
    assign occupancy  = count;

endmodule

// File: rtl/decode_stage_rv.sv
// RV32I decode stage: fetch handshake in, synchronous regfile read,
// decoded micro-ops buffered in an ID/EX queue toward EX.
module decode_stage_rv #(
    parameter int XLEN      = 32,
    parameter int REG_AW    = 5,
    parameter int ALUOP_W   = 5,
    parameter int OUT_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_if_valid,
    output logic                       o_if_ready,
    input  logic [31:0]                i_instruction,
    input  logic [XLEN-1:0]            i_pc,
    output logic [REG_AW-1:0]          o_addr1,
    output logic [REG_AW-1:0]          o_addr2,
    input  logic [XLEN-1:0]            i_reg_read_data1,
    input  logic [XLEN-1:0]            i_reg_read_data2,
    output logic                       o_ex_valid,
    input  logic                       i_ex_ready,
    output logic [XLEN-1:0]            o_operand1,
    output logic [XLEN-1:0]            o_operand2,
    output logic [XLEN-1:0]            o_store_data,
    output logic [ALUOP_W-1:0]         o_ALUop,
    output logic                       o_mem_read,
    output logic                       o_mem_write,
    output logic                       o_reg_write,
    output logic [REG_AW-1:0]          o_rd,
    output logic                       o_illegal,
    output logic [$clog2(OUT_DEPTH):0] o_occupancy
);

    import rv_decode_pkg::*;

    localparam int OCC_W = $clog2(OUT_DEPTH) + 1;
    localparam logic [OCC_W-1:0] FULL = OCC_W'(OUT_DEPTH);

    dec_state_t       state;
    dec_state_t       state_nxt;
    logic [31:0]      inst_q;
    logic [XLEN-1:0]  pc_q;
    logic             accept;
    logic             push;
    logic [OCC_W-1:0] occ;
    logic             head_valid;
    id_ex_t           entry;
    id_ex_t           head;

    logic [6:0]       opc;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic [XLEN-1:0]  imm_i;
    logic [XLEN-1:0]  imm_s;
    logic [XLEN-1:0]  imm_u;
    logic [XLEN-1:0]  imm_sh;
    logic [XLEN-1:0]  imm;
    imm_type_t        imm_sel;
    logic             use_rs1;
    logic             use_rs2;
    logic             use_pc;
    logic             is_store;
    logic [4:0]       alu;
    logic             mr;
    logic             mw;
    logic             rw;
    logic             ill;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (i_flush) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:  if (accept) state_nxt = S_READ;
                S_READ:  state_nxt = S_PUSH;
                S_PUSH:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_if_ready = 1'b0;
        push       = 1'b0;
        unique case (state)
            S_IDLE:  o_if_ready = rst && !i_flush && (occ < FULL);
            S_PUSH:  push = !i_flush;
            default: ;
        endcase
    end

    assign accept = o_if_ready && i_if_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_q <= '0;
            pc_q   <= '0;
        end else if (accept) begin
            inst_q <= i_instruction;
            pc_q   <= i_pc;
        end
    end

    // Addresses come from the latched word, so they stay put until
    // the next accept and the regfile sees them during READ.
    assign o_addr1 = REG_AW'(inst_q[19:15]);
    assign o_addr2 = REG_AW'(inst_q[24:20]);

    assign opc = inst_q[6:0];
    assign f3  = inst_q[14:12];
    assign f7  = inst_q[31:25];

    assign imm_i  = XLEN'($signed(inst_q[31:20]));
    assign imm_s  = XLEN'($signed({inst_q[31:25], inst_q[11:7]}));
    assign imm_u  = XLEN'($signed({inst_q[31:12], 12'b0}));
    assign imm_sh = XLEN'(inst_q[24:20]);

    always_comb begin
        imm_sel  = IMM_NONE;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        use_pc   = 1'b0;
        is_store = 1'b0;
        alu      = ALU_ILLEGAL;
        mr       = 1'b0;
        mw       = 1'b0;
        rw       = 1'b0;
        ill      = 1'b1;
        unique case (1'b1)
            (opc == OPC_OP): begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                rw      = 1'b1;
                ill     = 1'b0;
                unique case ({f7, f3})
                    {F7_BASE, 3'b000}: alu = ALU_ADD;
                    {F7_ALT,  3'b000}: alu = ALU_SUB;
                    {F7_BASE, 3'b100}: alu = ALU_XOR;
                    {F7_BASE, 3'b110}: alu = ALU_OR;
                    {F7_BASE, 3'b111}: alu = ALU_AND;
                    {F7_BASE, 3'b001}: alu = ALU_SLL;
                    {F7_BASE, 3'b101}: alu = ALU_SRL;
                    {F7_ALT,  3'b101}: alu = ALU_SRA;
                    {F7_BASE, 3'b010}: alu = ALU_SLT;
                    {F7_BASE, 3'b011}: alu = ALU_SLTU;
                    default:           ill = 1'b1;
                endcase
            end
            (opc == OPC_OP_IMM): begin
                use_rs1 = 1'b1;
                imm_sel = IMM_I;
                rw      = 1'b1;
                ill     = 1'b0;
                unique case (f3)
                    3'b000: alu = ALU_ADDI;
                    3'b100: alu = ALU_XORI;
                    3'b110: alu = ALU_ORI;
                    3'b111: alu = ALU_ANDI;
                    3'b010: alu = ALU_SLTI;
                    3'b011: alu = ALU_SLTIU;
                    3'b001: begin
                        imm_sel = IMM_SHAMT;
                        alu     = ALU_SLLI;
                        ill     = (f7 != F7_BASE);
                    end
                    default: begin
                        imm_sel = IMM_SHAMT;
                        alu     = (f7 == F7_ALT) ? ALU_SRAI : ALU_SRLI;
                        ill     = (f7 != F7_BASE) && (f7 != F7_ALT);
                    end
                endcase
            end
            (opc == OPC_LOAD): begin
                use_rs1 = 1'b1;
                imm_sel = IMM_I;
                alu     = ALU_ADDI;
                mr      = 1'b1;
                rw      = 1'b1;
                ill     = (f3 != 3'b010);
            end
            (opc == OPC_STORE): begin
                use_rs1  = 1'b1;
                imm_sel  = IMM_S;
                is_store = 1'b1;
                alu      = ALU_STORE;
                mw       = 1'b1;
                ill      = (f3 != 3'b010);
            end
            (opc == OPC_LUI): begin
                imm_sel = IMM_U;
                alu     = ALU_ADDI;
                rw      = 1'b1;
                ill     = 1'b0;
            end
            (opc == OPC_AUIPC): begin
                use_pc  = 1'b1;
                imm_sel = IMM_U;
                alu     = ALU_ADDI;
                rw      = 1'b1;
                ill     = 1'b0;
            end
            default: ill = 1'b1;
        endcase
        // Illegal words still flow to EX, but as an inert micro-op.
        if (ill) begin
            imm_sel  = IMM_NONE;
            use_rs1  = 1'b0;
            use_rs2  = 1'b0;
            use_pc   = 1'b0;
            is_store = 1'b0;
            alu      = ALU_ILLEGAL;
            mr       = 1'b0;
            mw       = 1'b0;
            rw       = 1'b0;
        end
    end

    always_comb begin
        imm = '0;
        unique case (imm_sel)
            IMM_I:     imm = imm_i;
            IMM_S:     imm = imm_s;
            IMM_U:     imm = imm_u;
            IMM_SHAMT: imm = imm_sh;
            default:   imm = '0;
        endcase
    end

    always_comb begin
        entry            = '0;
        entry.operand1   = use_rs1 ? i_reg_read_data1 :
                           use_pc  ? pc_q : '0;
        entry.operand2   = use_rs2 ? i_reg_read_data2 : imm;
        entry.store_data = is_store ? i_reg_read_data2 : '0;
        entry.alu_op     = alu;
        entry.mem_read   = mr;
        entry.mem_write  = mw;
        entry.reg_write  = rw;
        entry.rd         = (is_store || ill) ? '0 : inst_q[11:7];
        entry.illegal    = ill;
    end

    idex_queue #(
        .WIDTH ($bits(id_ex_t)),
        .DEPTH (OUT_DEPTH)
    ) u_idex_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (i_flush),
        .push       (push),
        .push_data  (entry),
        .pop        (i_ex_ready),
        .head_valid (head_valid),
        .head_data  (head),
        .occupancy  (occ)
    );

    assign o_ex_valid   = head_valid;
    assign o_operand1   = head.operand1;
    assign o_operand2   = head.operand2;
    assign o_store_data = head.store_data;
    assign o_ALUop      = head.alu_op;
    assign o_mem_read   = head.mem_read;
    assign o_mem_write  = head.mem_write;
    assign o_reg_write  = head.reg_write;
    assign o_rd         = head.rd;
    assign o_illegal    = head.illegal;
    assign o_occupancy  = occ;

endmodule

// File: tb/tb_decode_stage_rv.sv
// Directed bench for decode_stage_rv: scoreboard of expected ID/EX
// entries, popped and compared as the queue head is consumed.
module tb_decode_stage_rv;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] sd;
        logic [4:0]  alu;
        logic        mr;
        logic        mw;
        logic        rw;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_if_valid = 1'b0;
    logic        i_ex_ready = 1'b0;
    logic [31:0] i_instruction = '0;
    logic [31:0] i_pc = '0;
    logic [31:0] rd1 = '0;
    logic [31:0] rd2 = '0;

    logic        o_if_ready;
    logic [4:0]  o_addr1;
    logic [4:0]  o_addr2;
    logic        o_ex_valid;
    logic [31:0] o_operand1;
    logic [31:0] o_operand2;
    logic [31:0] o_store_data;
    logic [4:0]  o_ALUop;
    logic        o_mem_read;
    logic        o_mem_write;
    logic        o_reg_write;
    logic [4:0]  o_rd;
    logic        o_illegal;
    logic [1:0]  o_occupancy;

    logic [31:0] rf [32];
    exp_t        sb [$];
    int          vectors = 0;
    int          miscompares = 0;

    decode_stage_rv dut (
        .clk              (clk),
        .rst              (rst),
        .i_flush          (i_flush),
        .i_if_valid       (i_if_valid),
        .o_if_ready       (o_if_ready),
        .i_instruction    (i_instruction),
        .i_pc             (i_pc),
        .o_addr1          (o_addr1),
        .o_addr2          (o_addr2),
        .i_reg_read_data1 (rd1),
        .i_reg_read_data2 (rd2),
        .o_ex_valid       (o_ex_valid),
        .i_ex_ready       (i_ex_ready),
        .o_operand1       (o_operand1),
        .o_operand2       (o_operand2),
        .o_store_data     (o_store_data),
        .o_ALUop          (o_ALUop),
        .o_mem_read       (o_mem_read),
        .o_mem_write      (o_mem_write),
        .o_reg_write      (o_reg_write),
        .o_rd             (o_rd),
        .o_illegal        (o_illegal),
        .o_occupancy      (o_occupancy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd1 <= rf[o_addr1];
        rd2 <= rf[o_addr2];
    end

    function automatic exp_t mk(
        input logic [31:0] op1,
        input logic [31:0] op2,
        input logic [31:0] sd,
        input int          alu,
        input logic        mr,
        input logic        mw,
        input logic        rw,
        input int          rd,
        input logic        ill
    );
        exp_t e;
        e.op1 = op1;
        e.op2 = op2;
        e.sd  = sd;
        e.alu = 5'(alu);
        e.mr  = mr;
        e.mw  = mw;
        e.rw  = rw;
        e.rd  = 5'(rd);
        e.ill = ill;
        return e;
    endfunction

    task automatic check(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(
        input logic [31:0] inst,
        input logic [31:0] pc,
        input exp_t        e
    );
        int n;
        n = 0;
        i_instruction = inst;
        i_pc          = pc;
        i_if_valid    = 1'b1;
        while (!o_if_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("issue_ready", 32'(o_if_ready), 32'd1);
        sb.push_back(e);
        @(posedge clk);
        #1 i_if_valid = 1'b0;
    endtask

    task automatic pop_step(input string tag);
        exp_t e;
        int   n;
        n = 0;
        while (!o_ex_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(o_ex_valid), 32'd1);
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_op1"}, o_operand1, e.op1);
            check({tag, "_op2"}, o_operand2, e.op2);
            check({tag, "_sd"}, o_store_data, e.sd);
            check({tag, "_alu"}, 32'(o_ALUop), 32'(e.alu));
            check({tag, "_mr"}, 32'(o_mem_read), 32'(e.mr));
            check({tag, "_mw"}, 32'(o_mem_write), 32'(e.mw));
            check({tag, "_rw"}, 32'(o_reg_write), 32'(e.rw));
            check({tag, "_ill"}, 32'(o_illegal), 32'(e.ill));
            if (!e.ill) begin
                check({tag, "_rd"}, 32'(o_rd), 32'(e.rd));
            end
        end
        i_ex_ready = 1'b1;
        @(posedge clk);
        #1 i_ex_ready = 1'b0;
    endtask

    localparam logic [31:0] I_ADDI_M1 = 32'hFFF08293;
    localparam logic [31:0] I_SW      = 32'h0021A423;
    localparam logic [31:0] I_SUB     = 32'h402081B3;
    localparam logic [31:0] I_LUI     = 32'h123453B7;
    localparam logic [31:0] I_AUIPC   = 32'hFFFFF497;
    localparam logic [31:0] I_LW      = 32'hFFC1A503;
    localparam logic [31:0] I_ADDI5   = 32'h00508313;
    localparam logic [31:0] I_XORI    = 32'h0F014393;
    localparam logic [31:0] I_SRAI    = 32'h4041D413;
    localparam logic [31:0] I_BADSLL  = 32'h40109093;

    initial begin
        exp_t ea;
        exp_t eb;
        exp_t ec;
        for (int i = 0; i < 32; i++) begin
            rf[i] = '0;
        end
        rf[1] = 32'h10;
        rf[2] = 32'hCAFE;
        rf[3] = 32'h100;
        ea = mk(32'h10, 32'h5, 0, 10, 0, 0, 1, 6, 0);
        eb = mk(32'hCAFE, 32'hF0, 0, 11, 0, 0, 1, 7, 0);
        ec = mk(32'h100, 32'h4, 0, 16, 0, 0, 1, 8, 0);

        repeat (2) @(negedge clk);
        check("rst_if_ready", 32'(o_if_ready), 32'd0);
        check("rst_ex_valid", 32'(o_ex_valid), 32'd0);
        check("rst_occ", 32'(o_occupancy), 32'd0);
        check("rst_op1", o_operand1, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rel_if_ready", 32'(o_if_ready), 32'd1);

        issue(I_ADDI_M1, 32'h1000,
              mk(32'h10, 32'hFFFFFFFF, 0, 10, 0, 0, 1, 5, 0));
        check("lat_e0", 32'(o_ex_valid), 32'd0);
        @(posedge clk);
        #1 check("lat_e1", 32'(o_ex_valid), 32'd0);
        @(posedge clk);
        #1 check("lat_e2", 32'(o_ex_valid), 32'd1);
        pop_step("addi");

        issue(I_SW, 32'h1004,
              mk(32'h100, 32'h8, 32'hCAFE, 20, 0, 1, 0, 0, 0));
        pop_step("sw");

        issue(I_SUB, 32'h1008,
              mk(32'h10, 32'hCAFE, 0, 1, 0, 0, 1, 3, 0));
        issue(I_LUI, 32'h100C,
              mk(32'h0, 32'h12345000, 0, 10, 0, 0, 1, 7, 0));
        pop_step("sub");
        pop_step("lui");

        issue(I_AUIPC, 32'h2000,
              mk(32'h2000, 32'hFFFFF000, 0, 10, 0, 0, 1, 9, 0));
        pop_step("auipc");
        issue(I_LW, 32'h2004,
              mk(32'h100, 32'hFFFFFFFC, 0, 10, 1, 0, 1, 10, 0));
        pop_step("lw");

        issue(I_ADDI5, 32'h3000, ea);
        issue(I_XORI, 32'h3004, eb);
        repeat (4) @(negedge clk);
        check("bp_occ2", 32'(o_occupancy), 32'd2);
        check("bp_valid", 32'(o_ex_valid), 32'd1);
        i_instruction = I_SRAI;
        i_pc          = 32'h3008;
        i_if_valid    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_if_ready", 32'(o_if_ready), 32'd0);
            check("bp_head_hold", o_operand1, 32'h10);
        end
        check("bp_occ_hold", 32'(o_occupancy), 32'd2);
        pop_step("bp_a");
        issue(I_SRAI, 32'h3008, ec);
        pop_step("bp_b");
        pop_step("bp_c");
        @(negedge clk);
        check("bp_drained", 32'(o_occupancy), 32'd0);

        issue(I_ADDI5, 32'h4000, ea);
        repeat (3) @(negedge clk);
        check("fl_occ1", 32'(o_occupancy), 32'd1);
        issue(I_XORI, 32'h4004, eb);
        @(negedge clk);
        @(negedge clk);
        i_flush = 1'b1;
        #1 check("fl_if_ready_lo", 32'(o_if_ready), 32'd0);
        @(negedge clk);
        i_flush = 1'b0;
        #1;
        check("fl_occ0", 32'(o_occupancy), 32'd0);
        check("fl_valid0", 32'(o_ex_valid), 32'd0);
        check("fl_if_ready", 32'(o_if_ready), 32'd1);
        sb.delete();
        repeat (3) @(negedge clk);
        check("fl_no_enq", 32'(o_occupancy), 32'd0);

        issue(32'hFFFFFFFF, 32'h5000,
              mk(0, 0, 0, 31, 0, 0, 0, 0, 1));
        pop_step("ill_ones");
        issue(I_BADSLL, 32'h5004,
              mk(0, 0, 0, 31, 0, 0, 0, 0, 1));
        pop_step("ill_slli");

        issue(I_ADDI5, 32'h6000, ea);
        repeat (3) @(negedge clk);
        check("rr_valid", 32'(o_ex_valid), 32'd1);
        issue(I_SW, 32'h6004,
              mk(32'h100, 32'h8, 32'hCAFE, 20, 0, 1, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rr_if_ready", 32'(o_if_ready), 32'd0);
        check("rr_valid0", 32'(o_ex_valid), 32'd0);
        check("rr_occ", 32'(o_occupancy), 32'd0);
        check("rr_op1", o_operand1, 32'd0);
        check("rr_op2", o_operand2, 32'd0);
        check("rr_alu", 32'(o_ALUop), 32'd0);
        check("rr_rw", 32'(o_reg_write), 32'd0);
        check("rr_rd", 32'(o_rd), 32'd0);
        check("rr_addr1", 32'(o_addr1), 32'd0);
        check("rr_addr2", 32'(o_addr2), 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        #1 check("rr_rel_ready", 32'(o_if_ready), 32'd1);

        issue(I_ADDI_M1, 32'h7000,
              mk(32'h10, 32'hFFFFFFFF, 0, 10, 0, 0, 1, 5, 0));
        pop_step("recover");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/decode_stage_rv.md
Name: decode_stage_rv

Overview:
Parametrised RV32I instruction-decode stage that sits between the fetch stage and the ALU/EX stage. It replaces level/pulse strobes with valid/ready handshakes and drives a synchronous register file. Immediates are fully sign-extended, and LUI/AUIPC and illegal-instruction flagging are supported. Decoded micro-ops are buffered in an OUT_DEPTH-entry ID/EX queue, so the EX stage can back-pressure without stalling decode mid-instruction.

Parameters:
XLEN, 32, data and operand width
REG_AW, 5, register-file address width
ALUOP_W, 5, ALU opcode width
OUT_DEPTH, 2, ID/EX queue entries; must be a power of two and at least 2

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
i_flush  in  1  synchronous flush from the control unit
i_if_valid  in  1  fetch presents i_instruction/i_pc
o_if_ready  out  1  decode accepts this cycle
i_instruction  in  32  instruction word
i_pc  in  XLEN  PC of i_instruction
o_addr1  out  REG_AW  register-file read address rs1
o_addr2  out  REG_AW  register-file read address rs2
i_reg_read_data1  in  XLEN  rs1 data, valid one cycle after the address
i_reg_read_data2  in  XLEN  rs2 data, valid one cycle after the address
o_ex_valid  out  1  queue head valid
i_ex_ready  in  1  EX consumes the head
o_operand1  out  XLEN  ALU operand A
o_operand2  out  XLEN  ALU operand B
o_store_data  out  XLEN  rs2 data for stores, else 0
o_ALUop  out  ALUOP_W  ALU operation
o_mem_read  out  1  load
o_mem_write  out  1  store
o_reg_write  out  1  writes rd
o_rd  out  REG_AW  destination register
o_illegal  out  1  unsupported encoding
o_occupancy  out  $clog2(OUT_DEPTH)+1  queue entry count

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE and the queue empties. All outputs are 0, except o_if_ready, which is 1 once rst is released.
- FSM states:
  - IDLE: o_if_ready = !i_flush && occupancy < OUT_DEPTH. On accept, latch the instruction and PC, then go to READ.
  - READ: o_addr1/o_addr2 are driven from the latched rs1/rs2 (they hold their value in every state); the register file samples them. Go to PUSH.
  - PUSH: sample i_reg_read_data*, form the entry, enqueue it, go to IDLE.
- Latency: o_ex_valid rises 2 edges after the accept edge. Throughput is 1 instruction per 3 cycles.
- At most one instruction is in flight. Because admission requires occupancy < OUT_DEPTH, PUSH can never overflow.
- Queue: circular buffer with wrapping read/write pointers.
  - Pop when o_ex_valid && i_ex_ready.
  - Push and pop in the same cycle leave occupancy unchanged.
  - Head outputs are registered and stable while i_ex_ready is 0.
- i_flush (sampled at the edge, highest priority):
  - Empties the queue and aborts any READ/PUSH (no enqueue); FSM goes to IDLE.
  - o_if_ready is 0 while i_flush is 1.
  - A flush coinciding with PUSH discards that entry.
- Immediate forms, all sign-extended to XLEN:
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - U: {inst[31:12], 12'b0}
- Decode table:
  - OP 0110011: R-type. op1=rs1, op2=rs2, reg_write=1. ALUop from {funct7, funct3}: ADD 0, SUB 1, XOR 2, OR 3, AND 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9.
  - OP-IMM 0010011: op1=rs1, op2=immI, reg_write=1. ALUop: ADDI 10, XORI 11, ORI 12, ANDI 13, SLLI 14, SRLI 15, SRAI 16, SLTI 17, SLTIU 18.
    - Shifts: op2 = {0, shamt}.
    - SRAI is selected when funct7 = 0100000. Any other funct7 on a shift is illegal.
  - LOAD 0000011 (funct3 010 only): op1=rs1, op2=immI, ALUop=10, mem_read=1, reg_write=1.
  - STORE 0100011 (funct3 010 only): op1=rs1, op2=immS, store_data=rs2, ALUop=20, mem_write=1, rd=0, reg_write=0.
  - LUI 0110111: op1=0, op2=immU, ALUop=10, reg_write=1.
  - AUIPC 0010111: op1=pc, op2=immU, ALUop=10, reg_write=1.
  - Anything else: illegal=1, ALUop=31, mem_read/mem_write/reg_write=0, operands 0. The entry is still enqueued.
- rd=0 with reg_write=1 is passed through unchanged; suppression is handled by the register file.

Decomposition:
- Package rv_decode_pkg holds:
  - opcode constants;
  - ALUop constants (0–20, plus ILLEGAL=31);
  - immediate-type enum;
  - packed ID/EX entry struct: operand1, operand2, store_data, ALUop, mem_read, mem_write, reg_write, rd, illegal.
- One sub-module, idex_queue: a generic parametrised FIFO (width, depth) with flush and occupancy.

Test Plan:
- ADDI x5,x1,-1 (0xFFF08293), rs1 data=0x10, i_ex_ready=1 → 2 edges after accept: op1=0x10, op2=0xFFFFFFFF, ALUop=10, rd=5, reg_write=1.
- SW x2,8(x3) (0x0021A423), rs1=0x100, rs2=0xCAFE → op1=0x100, op2=8, store_data=0xCAFE, ALUop=20, mem_write=1, reg_write=0.
- SUB x3,x1,x2 (0x402081B3), then LUI x7,0x12345 (0x123453B7) → ALUop=1, rd=3; then op1=0, op2=0x12345000, ALUop=10, rd=7.
- i_ex_ready=0 while issuing 3 instructions with OUT_DEPTH=2 → occupancy reaches 2, o_if_ready=0, the 3rd is held. Releasing i_ex_ready drains entries in order with no loss.
- i_flush asserted during PUSH with 1 entry queued → occupancy=0 and o_ex_valid=0 next cycle, the in-flight instruction is not enqueued, and o_if_ready returns to 1.
- 0xFFFFFFFF → o_illegal=1, ALUop=31, reg_write=0, mem_read=0, mem_write=0. Asserting rst low mid-READ → all outputs 0 immediately.
